reg_status: RTL
===============

REG_STATUS -- requirements
Module: reg_status

Interface
REQ-001 SHALL have ports: clock  in  1  rising-edge clock.
REQ-002 SHALL have ports: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: emit_valid  in  1  issue request; emit_ready  out  1  issue accepted this cycle.
REQ-004 SHALL have ports: emit_rs1, emit_rs2  in  3 each  source register indices; emit_rd  in  3  destination index; emit_wr  in  1  instruction writes emit_rd; emit_tag  in  3  reservation-station tag of the instruction (1..7; 0 reserved).
REQ-005 SHALL have ports: op1_val, op2_val  out  16 each  operand values; op1_tag, op2_tag  out  3 each  producer tag (0 = value valid).
REQ-006 SHALL have ports: rd_addr1, rd_addr2  out  3 each  bank read addresses; rd_data1, rd_data2  in  16 each  bank read data (combinational).
REQ-007 SHALL have ports: cdb_valid  in  1; cdb_tag  in  3; cdb_data  in  16  common data bus broadcast.
REQ-008 SHALL have ports: wr_en  out  1; wr_addr  out  3; wr_data  out  16  bank write port (bank writes on clock edge).
REQ-009 SHALL have ports: busy_count  out  4  number of registers with nonzero tag.

Function
REQ-010 SHALL hold per-register state Qi[0..7] (3 bits, 0 = not pending).
REQ-011 SHALL implement FSM INIT -> RUN; INIT drives wr_en=1, wr_data=0, wr_addr=sweep counter 0..7, one register per cycle; after address 7, RUN next cycle.
REQ-012 SHALL hold emit_ready=0 in INIT and emit_ready=1 in RUN; issue occurs iff emit_valid && emit_ready.
REQ-013 SHALL drive rd_addr1=emit_rs1, rd_addr2=emit_rs2 combinationally in all states.
REQ-014 SHALL produce opN_* combinationally with priority: (a) Qi[rsN]!=0 and cdb_valid and cdb_tag==Qi[rsN] -> cdb_data, tag 0; (b) Qi[rsN]!=0 -> tag Qi[rsN], value 0; (c) pending registered write to rsN -> wr_data, tag 0; (d) else rd_dataN, tag 0.
REQ-015 SHALL read operands from pre-issue state (rs==rd of same instruction sees old Qi).
REQ-016 SHALL, in RUN on cdb_valid with cdb_tag!=0, find register r with Qi[r]==cdb_tag, clear Qi[r] next edge, and register a bank write (wr_en=1, wr_addr=r, wr_data=cdb_data) one cycle later.
REQ-017 SHALL ignore CDB broadcasts with no matching Qi or cdb_tag==0 (wr_en=0).
REQ-018 SHALL on issue with emit_wr=1 and emit_tag!=0 set Qi[emit_rd]=emit_tag next edge; emit_wr=0 or emit_tag=0 changes no Qi.
REQ-019 SHALL, when issue and CDB hit the same register in one cycle, set Qi to emit_tag (issue wins) while still performing the CDB bank write.
REQ-020 SHALL ignore cdb_valid during INIT.
REQ-021 SHALL update busy_count registered, consistent with Qi after each edge (0..8).

Reset
REQ-022 SHALL on reset_n=0 immediately: state INIT, sweep counter 0, all Qi=0, pending write cleared, busy_count=0, emit_ready=0.
REQ-023 SHALL restart the full INIT sweep on reset asserted mid-INIT or mid-RUN; wr_en SHALL be 0 while reset_n=0.

Structure
REQ-024 SHALL place constants TAG_NONE=0, NUM_REGS=8, tag/data widths and FSM state encoding in a shared package.
REQ-025 SHALL be a single module with no sub-modules; Qi match logic SHALL be a parameterized loop over NUM_REGS.

Verification
REQ-026 SHALL cover: release reset -> wr_en=1 for exactly 8 cycles, wr_addr 0..7, wr_data 0, then emit_ready=1.
REQ-027 SHALL cover: issue rd=3 tag=5; next cycle issue rs1=3 -> op1_tag=5; cdb tag=5 data=0x00AB -> Qi[3]=0, next cycle wr_en=1 addr=3 data=0x00AB.
REQ-028 SHALL cover: Qi[2]=4; same cycle cdb tag=4 data=0x1234 and issue rs2=2 -> op2_tag=0, op2_val=0x1234.
REQ-029 SHALL cover: Qi[6]=1; same cycle cdb tag=1 and issue rd=6 tag=7 -> Qi[6]=7, bank write addr=6 still occurs, busy_count unchanged.
REQ-030 SHALL cover: issue rs1=rd=4 tag=2 with Qi[4]=0 and bank R4=0x0055 -> op1_val=0x0055, op1_tag=0, then Qi[4]=2.
REQ-031 SHALL cover: reset_n low mid-RUN with 3 busy registers -> busy_count=0 and all opN_tag=0 immediately, INIT sweep repeats.

Source files
------------

// File: rtl/reg_status_pkg.sv
// Shared constants, types and FSM encoding for the register status table.
package reg_status_pkg;

    localparam int NUM_REGS = 8;
    localparam int IDX_W    = 3;
    localparam int TAG_W    = 3;
    localparam int DATA_W   = 16;
    localparam int CNT_W    = 4;

    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [TAG_W-1:0]  tag_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    // Tag value meaning "register value is architecturally valid".
    localparam tag_t TAG_NONE = '0;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Resolved source operand: tag 0 means val is usable.
    typedef struct packed {
        tag_t  tag;
        data_t val;
    } operand_t;

endpackage

// File: rtl/reg_status_if.sv
// Issue-side bus: instruction emit handshake plus the resolved operands.
interface reg_status_if;
    import reg_status_pkg::*;

    logic  emit_valid;
    logic  emit_ready;
    idx_t  emit_rs1;
    idx_t  emit_rs2;
    idx_t  emit_rd;
    logic  emit_wr;
    tag_t  emit_tag;
    data_t op1_val;
    data_t op2_val;
    tag_t  op1_tag;
    tag_t  op2_tag;

    modport master (
        output emit_valid, emit_rs1, emit_rs2, emit_rd, emit_wr, emit_tag,
        input  emit_ready, op1_val, op2_val, op1_tag, op2_tag
    );

    modport slave (
        input  emit_valid, emit_rs1, emit_rs2, emit_rd, emit_wr, emit_tag,
        output emit_ready, op1_val, op2_val, op1_tag, op2_tag
    );

endinterface

// File: rtl/reg_status.sv
// Register status table (Qi per architectural register) for a Tomasulo-style
// issue stage. Clears the external register bank after reset, resolves source
// operands against Qi / CDB / pending bank write, and retires CDB results
// into the bank one cycle after the broadcast.
module reg_status
    import reg_status_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    reg_status_if.slave emit,
    output idx_t        rd_addr1,
    output idx_t        rd_addr2,
    input  data_t       rd_data1,
    input  data_t       rd_data2,
    input  logic        cdb_valid,
    input  tag_t        cdb_tag,
    input  data_t       cdb_data,
    output logic        wr_en,
    output idx_t        wr_addr,
    output data_t       wr_data,
    output cnt_t        busy_count
);

    // Operand priority: CDB bypass, still-pending producer, bank write in
    // flight this cycle, then the bank itself.
    function automatic operand_t resolve_operand(
        input tag_t  q,
        input idx_t  rs,
        input logic  cdb_v,
        input tag_t  cdb_t,
        input data_t cdb_d,
        input logic  wen,
        input idx_t  waddr,
        input data_t wdata,
        input data_t bank
    );
        operand_t o;
        o.tag = TAG_NONE;
        o.val = bank;
        if (q != TAG_NONE && cdb_v && cdb_t == q) begin
            o.val = cdb_d;
        end else if (q != TAG_NONE) begin
            o.tag = q;
            o.val = '0;
        end else if (wen && waddr == rs) begin
            o.val = wdata;
        end
        return o;
    endfunction

    function automatic cnt_t count_busy(input tag_t q [NUM_REGS]);
        cnt_t c;
        c = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (q[r] != TAG_NONE) c = c + cnt_t'(1);
        end
        return c;
    endfunction

    state_t   state_q, state_d;
    idx_t     sweep_q, sweep_d;
    tag_t     qi_q [NUM_REGS];
    tag_t     qi_d [NUM_REGS];
    logic     cdb_hit;
    idx_t     cdb_idx;
    logic     issue_set;
    logic     pend_vld_p1;
    idx_t     pend_addr_p1;
    data_t    pend_data_p1;
    operand_t op1, op2;

    // FSM next state and bank write port; wr_en is forced low during reset.
    always_comb begin
        state_d         = state_q;
        sweep_d         = sweep_q;
        wr_en           = pend_vld_p1;
        wr_addr         = pend_addr_p1;
        wr_data         = pend_data_p1;
        emit.emit_ready = 1'b0;
        case (state_q)
            ST_INIT: begin
                wr_en   = reset_n;
                wr_addr = sweep_q;
                wr_data = '0;
                sweep_d = sweep_q + idx_t'(1);
                if (sweep_q == idx_t'(NUM_REGS - 1)) state_d = ST_RUN;
            end
            ST_RUN: begin
                emit.emit_ready = 1'b1;
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Locate the register waiting on the broadcast tag (lowest index wins).
    always_comb begin
        cdb_hit = 1'b0;
        cdb_idx = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (!cdb_hit && state_q == ST_RUN && cdb_valid &&
                cdb_tag != TAG_NONE && qi_q[r] == cdb_tag) begin
                cdb_hit = 1'b1;
                cdb_idx = idx_t'(r);
            end
        end
    end

    assign issue_set = emit.emit_valid && emit.emit_ready &&
                       emit.emit_wr && (emit.emit_tag != TAG_NONE);

    // Next Qi: CDB clears first, a same-cycle issue to that register overrides.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) qi_d[r] = qi_q[r];
        if (cdb_hit) qi_d[cdb_idx] = TAG_NONE;
        if (issue_set) qi_d[emit.emit_rd] = emit.emit_tag;
    end

    assign rd_addr1 = emit.emit_rs1;
    assign rd_addr2 = emit.emit_rs2;

    // Operands come from pre-issue Qi, so rs == rd sees the old producer.
    assign op1 = resolve_operand(qi_q[emit.emit_rs1], emit.emit_rs1, cdb_valid,
                                 cdb_tag, cdb_data, wr_en, wr_addr, wr_data,
                                 rd_data1);
    assign op2 = resolve_operand(qi_q[emit.emit_rs2], emit.emit_rs2, cdb_valid,
                                 cdb_tag, cdb_data, wr_en, wr_addr, wr_data,
                                 rd_data2);

    assign emit.op1_tag = op1.tag;
    assign emit.op1_val = op1.val;
    assign emit.op2_tag = op2.tag;
    assign emit.op2_val = op2.val;

    // FSM state and init sweep counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    // ---- stage p1: Qi update, busy count, pending bank write control ----
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NUM_REGS; r++) qi_q[r] <= TAG_NONE;
            busy_count   <= '0;
            pend_vld_p1  <= 1'b0;
            pend_addr_p1 <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) qi_q[r] <= qi_d[r];
            busy_count   <= count_busy(qi_d);
            pend_vld_p1  <= cdb_hit;
            pend_addr_p1 <= cdb_idx;
        end
    end

    // Pending write data only meaningful alongside pend_vld_p1.
    always_ff @(posedge clock) begin
        if (cdb_hit) pend_data_p1 <= cdb_data;
    end

endmodule
